mem_responder: RTL

//  Memory-side responder for the microcoded controller. It decodes the memory read/write

---
 rtl/mem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Multi-cycle word memory model answering the microcoded controller's bus strobes.
// Latency: wait_ low for LATENCY cycles per access, then one DONE cycle (LATENCY+2 request spacing).
// Backpressure: wait_ low stalls the controller; strobes seen outside IDLE are ignored. MEM_PROTO_CHK_EN adds the err checker.
module mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wait_,
    output logic              err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              wait_q, wait_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            op_wr_q       <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            wait_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            op_wr_q       <= op_wr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            wait_q        <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        op_wr_d       = op_wr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        wait_d        = 1'b1;
        mem_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_wr || mem_rd) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_wr_d = mem_wr;
                    cnt_d   = CNT_INIT;
                    wait_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                wait_d = 1'b0;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d       = mem[addr_q];
                        rdata_valid_d = 1'b1;
                    end
                    wait_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Swallows a strobe still held while the controller leaves its wait state.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array is never cleared; reset only blocks a write that would land this cycle.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign wait_       = wait_q;

`ifdef MEM_PROTO_CHK_EN
    logic err_q;
    logic rd_prev, wr_prev;
    logic collide, rise_busy;

    assign collide   = (state_q == IDLE) && mem_rd && mem_wr;
    assign rise_busy = (state_q == BUSY) && ((mem_rd && !rd_prev) || (mem_wr && !wr_prev));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q   <= 1'b0;
            rd_prev <= 1'b0;
            wr_prev <= 1'b0;
        end else begin
            rd_prev <= mem_rd;
            wr_prev <= mem_wr;
            if (collide || rise_busy) begin
                err_q <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    int unsigned cycle_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 0;
        end else begin
            cycle_cnt <= cycle_cnt + 1;
            if (collide)
                $display("mem_responder: cycle %0d protocol error: rd and wr together in IDLE", cycle_cnt);
            if (rise_busy)
                $display("mem_responder: cycle %0d protocol error: strobe rose during BUSY", cycle_cnt);
        end
    end
`endif

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
